// File: rtl/cnn_sdiv_23s_14s_seq.sv
// cnn_sdiv_23s_14s_seq: multi-cycle signed restoring divider with C truncation semantics.
// Define CNN_SDIV_SAT_EN to clamp the quotient to OUT_WIDTH signed range, flagging clamps on ovf.
module cnn_sdiv_23s_14s_seq #(
  parameter int DIVIDEND_WIDTH = 23,
  parameter int DIVISOR_WIDTH  = 14,
  parameter int OUT_WIDTH      = 9
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DIVIDEND_WIDTH-1:0] dividend,
  input  logic [DIVISOR_WIDTH-1:0]  divisor,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DIVIDEND_WIDTH-1:0] quotient,
  output logic [DIVISOR_WIDTH-1:0]  remainder,
  output logic                      dbz,
  output logic                      ovf
);
  localparam int DW = DIVIDEND_WIDTH;
  localparam int VW = DIVISOR_WIDTH;
  localparam int CW = $clog2(DW);
  localparam logic [CW-1:0] LAST = CW'(DW - 1);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state;
  logic [DW-1:0] a;
  logic [VW-1:0] b, r, diff;
  logic [VW:0] rem_sh;
  logic [CW-1:0] cnt;
  logic sign_q, sign_r, ge, ovf_fix;
  logic [DW-1:0] q_fix;
  // a doubles as the dividend shifter and the quotient accumulator
  assign rem_sh = {r, a[DW-1]};
  assign ge = rem_sh >= {1'b0, b};
  assign diff = rem_sh[VW-1:0] - b;
`ifdef CNN_SDIV_SAT_EN
  localparam logic signed [DW:0] QMAX = (DW+1)'((1 << (OUT_WIDTH - 1)) - 1);
  localparam logic signed [DW:0] QMIN = (DW+1)'(-(1 << (OUT_WIDTH - 1)));
  logic signed [DW:0] qs;
  assign qs = sign_q ? -$signed({1'b0, a}) : $signed({1'b0, a});
  assign ovf_fix = qs > QMAX || qs < QMIN;
  assign q_fix = qs > QMAX ? QMAX[DW-1:0] : qs < QMIN ? QMIN[DW-1:0] : qs[DW-1:0];
`else
  assign q_fix = sign_q ? -a : a;
  // only -2^(DW-1) / -1 yields a positive magnitude with the top bit set
  assign ovf_fix = !sign_q && a[DW-1];
`endif
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      dbz       <= 1'b0;
      ovf       <= 1'b0;
      a         <= '0;
      b         <= '0;
      r         <= '0;
      cnt       <= '0;
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a        <= dividend[DW-1] ? -dividend : dividend;
          b        <= divisor[VW-1] ? -divisor : divisor;
          r        <= '0;
          cnt      <= '0;
          sign_q   <= dividend[DW-1] ^ divisor[VW-1];
          sign_r   <= dividend[DW-1];
          in_ready <= 1'b0;
          state    <= CALC;
        end
        CALC: begin
          a     <= {a[DW-2:0], ge};
          r     <= ge ? diff : rem_sh[VW-1:0];
          cnt   <= cnt + 1'b1;
          state <= cnt == LAST ? FIX : CALC;
        end
        FIX: begin
          dbz       <= b == '0;
          ovf       <= b != '0 && ovf_fix;
          quotient  <= b == '0 ? '0 : q_fix;
          remainder <= b == '0 ? '0 : sign_r ? -r : r;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        default: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cnn_sdiv_23s_14s_seq.sv
// tb_cnn_sdiv_23s_14s_seq: directed and random checks of the signed divider against integer arithmetic.
module tb_cnn_sdiv_23s_14s_seq;
  logic ap_clk = 0, ap_rst = 1, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid, dbz, ovf;
  logic [22:0] dividend = 0, quotient;
  logic [13:0] divisor = 0, remainder;
  int tests = 0, failed = 0;
  cnn_sdiv_23s_14s_seq dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder), .dbz(dbz), .ovf(ovf)
  );
  always #5 ap_clk = ~ap_clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic void model(input int d, input int s, output logic [22:0] q,
                                output logic [13:0] r, output logic z, output logic o);
    int qi, ri;
    if (s == 0) begin
      q = 0; r = 0; z = 1; o = 0;
    end else begin
      qi = d / s;
      ri = d % s;
      z = 0;
      r = ri[13:0];
`ifdef CNN_SDIV_SAT_EN
      o = qi > 255 || qi < -256;
      qi = qi > 255 ? 255 : qi < -256 ? -256 : qi;
`else
      o = qi > 4194303;
`endif
      q = qi[22:0];
    end
  endfunction
  task automatic run_op(input int d, input int s, input int hold);
    logic [22:0] eq;
    logic [13:0] er;
    logic ez, eo;
    int lat;
    model(d, s, eq, er, ez, eo);
    chk("in_ready_idle", {31'd0, in_ready}, 1);
    dividend = 23'(d);
    divisor = 14'(s);
    in_valid = 1;
    @(posedge ap_clk); #1;
    in_valid = 0;
    dividend = 23'($urandom);
    divisor = 14'($urandom);
    chk("in_ready_busy", {31'd0, in_ready}, 0);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge ap_clk); #1;
      lat++;
    end
    chk("latency", lat, 24);
    chk($sformatf("quot %0d/%0d", d, s), {9'd0, quotient}, {9'd0, eq});
    chk($sformatf("rem %0d/%0d", d, s), {18'd0, remainder}, {18'd0, er});
    chk("dbz", {31'd0, dbz}, {31'd0, ez});
    chk("ovf", {31'd0, ovf}, {31'd0, eo});
    for (int i = 0; i < hold; i++) begin
      in_valid = i[0];
      dividend = 23'($urandom);
      @(posedge ap_clk); #1;
      chk("hold_valid", {31'd0, out_valid}, 1);
      chk("hold_ready", {31'd0, in_ready}, 0);
      chk("hold_quot", {9'd0, quotient}, {9'd0, eq});
      chk("hold_rem", {18'd0, remainder}, {18'd0, er});
    end
    in_valid = 0;
    out_ready = 1;
    @(posedge ap_clk); #1;
    out_ready = 0;
    chk("release_valid", {31'd0, out_valid}, 0);
    chk("release_ready", {31'd0, in_ready}, 1);
  endtask
  initial begin
    repeat (2) @(posedge ap_clk);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 1);
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_quot", {9'd0, quotient}, 0);
    chk("rst_rem", {18'd0, remainder}, 0);
    chk("rst_flags", {30'd0, dbz, ovf}, 0);
    ap_rst = 0;
    run_op(100, 7, 0);
    run_op(-100, 7, 0);
    run_op(100, -7, 0);
    run_op(-100, -7, 0);
    run_op(12345, 0, 0);
    run_op(77, 5, 0);
    run_op(-4194304, -1, 0);
    run_op(-4194304, 1, 0);
    run_op(4194303, -8192, 0);
    run_op(-4194304, 8191, 0);
    run_op(5000, 3, 0);
    run_op(-5000, 3, 0);
    run_op(700, 3, 0);
    run_op(-768, 3, 0);
    run_op(1234, 56, 5);
    // abort a division partway through CALC
    dividend = 23'd1000;
    divisor = 14'd3;
    in_valid = 1;
    @(posedge ap_clk); #1;
    in_valid = 0;
    repeat (9) @(posedge ap_clk);
    #1;
    ap_rst = 1;
    @(posedge ap_clk); #1;
    ap_rst = 0;
    chk("abort_out_valid", {31'd0, out_valid}, 0);
    chk("abort_in_ready", {31'd0, in_ready}, 1);
    run_op(50, 5, 0);
    for (int i = 0; i < 40; i++) begin
      int d, s;
      d = int'($signed(23'($urandom)));
      s = i % 3 == 0 ? int'($urandom_range(1, 20)) * ($urandom_range(0, 1) ? 1 : -1)
                     : int'($signed(14'($urandom)));
      run_op(d, s, i % 7 == 0 ? 2 : 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
